rd_line_fetch_ctrl: RTL
=======================

RD_LINE_FETCH_CTRL -- requirements
Module: rd_line_fetch_ctrl

Interface
REQ-001 Parameter AFIFO_DEPTH, default 4, request address FIFO depth; power of 2, >=2.
REQ-002 Parameter MAX_OUT, default 2, maximum lines in flight plus lines held in the return buffer; 1..2.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 fetch_req  input  1  requester line-fetch request valid.
REQ-006 fetch_addr  input  32  requester byte address.
REQ-007 fetch_ack  output  1  request accepted when fetch_req&&fetch_ack.
REQ-008 rstart_rq  output  1  one-cycle read start pulse to the read channel manager.
REQ-009 rin_addr  output  32  line-aligned read address, valid while rstart_rq=1.
REQ-010 rdat_m_valid  input  1  one-cycle pulse: 128-bit line returned.
REQ-011 rdat_m_data  input  128  returned line, sampled when rdat_m_valid=1.
REQ-012 line_valid  output  1  return buffer head valid.
REQ-013 line_data  output  128  head line data.
REQ-014 line_addr  output  32  line-aligned address of head line.
REQ-015 line_ready  input  1  requester consumes head when line_valid&&line_ready.
REQ-016 err_unexp  output  1  sticky: rdat_m_valid arrived with zero lines in flight.

Function
REQ-017 fetch_ack SHALL be 1 iff the address FIFO is not full; a same-cycle pop SHALL NOT raise fetch_ack.
REQ-018 An accepted request SHALL push {fetch_addr[31:4],4'h0} into the address FIFO.
REQ-019 The issue FSM SHALL have exactly two states, IDLE and ISSUE.
REQ-020 IDLE->ISSUE SHALL occur when the FIFO is non-empty and (inflight+ret_count) < MAX_OUT; otherwise the FSM SHALL stay in IDLE.
REQ-021 In ISSUE, the block SHALL drive rstart_rq=1 for exactly one cycle with rin_addr=FIFO head, pop the FIFO, push the address into the tag FIFO, increment inflight, and return to IDLE.
REQ-022 Consecutive rstart_rq pulses SHALL be separated by at least one cycle.
REQ-023 The earliest rstart_rq for a request accepted in cycle N SHALL be cycle N+2 (FIFO write N, IDLE->ISSUE decision N+1).
REQ-024 On rdat_m_valid with inflight>0, the block SHALL decrement inflight, pop the tag FIFO, and write {tag,rdat_m_data} into the 2-entry return buffer; line_valid SHALL assert the next cycle.
REQ-025 Lines SHALL be returned strictly in issue order.
REQ-026 Because of the credit rule in REQ-020, the return buffer SHALL never overflow; same-cycle write and pop SHALL both take effect.
REQ-027 On rdat_m_valid with inflight==0, err_unexp SHALL set and remain 1 until reset; the data SHALL be discarded and no counter SHALL change.
REQ-028 Same-cycle ISSUE increment and rdat_m_valid decrement SHALL leave inflight unchanged.
REQ-029 line_data and line_addr SHALL remain stable while line_valid=1 and line_ready=0.
REQ-030 inflight and ret_count widths SHALL hold 0..MAX_OUT; FIFO pointers SHALL wrap modulo AFIFO_DEPTH, with a count (or extra pointer bit) distinguishing full from empty.

Reset
REQ-031 Asserting rst_n=0 SHALL immediately set the FSM to IDLE and clear FIFO pointers, inflight, ret_count and err_unexp.
REQ-032 During reset: rstart_rq=0, rin_addr=0, line_valid=0, line_data=0, line_addr=0, err_unexp=0, fetch_ack=0.
REQ-033 fetch_ack SHALL be 1 from the first clock edge after deassertion.
REQ-034 Reset asserted mid-operation SHALL drop all queued and in-flight requests.
REQ-035 Lines that arrive after reset deassertion for requests dropped by REQ-034 SHALL set err_unexp.

Verification
REQ-036 Single fetch: fetch_addr=0x0000_1234 accepted in cycle 0 -> rstart_rq in cycle 2 with rin_addr=0x0000_1230; rdat_m_valid in cycle 10 with data D -> line_valid in cycle 11, line_addr=0x0000_1230, line_data=D.
REQ-037 Credit stall: 4 requests, line_ready=0, MAX_OUT=2 -> exactly 2 rstart_rq; after 2 returns nothing further issues until line_ready=1 pops a line, then the 3rd rstart_rq issues.
REQ-038 FIFO full: 5 back-to-back fetch_req with no issue credit (2 lines held) -> fetch_ack=0 on the 5th after 4 accepts; order 0x00,0x10,0x20,0x30 is preserved on rin_addr.
REQ-039 Unexpected return: rdat_m_valid with nothing in flight -> err_unexp=1, line_valid stays 0, and err_unexp persists until rst_n=0.
REQ-040 Reset mid-flight: one line in flight, rst_n pulsed low -> all outputs at reset values within the same cycle; a new request after reset issues normally.

Source files
------------

// File: rtl/rd_line_fetch_if.sv
// rd_line_fetch_if: requester, read-channel and line-return signals of the line fetch controller
interface rd_line_fetch_if;
  logic         fetch_req;
  logic [31:0]  fetch_addr;
  logic         fetch_ack;
  logic         rstart_rq;
  logic [31:0]  rin_addr;
  logic         rdat_m_valid;
  logic [127:0] rdat_m_data;
  logic         line_valid;
  logic [127:0] line_data;
  logic [31:0]  line_addr;
  logic         line_ready;
  logic         err_unexp;
  modport slave (
    input  fetch_req, fetch_addr, rdat_m_valid, rdat_m_data, line_ready,
    output fetch_ack, rstart_rq, rin_addr, line_valid, line_data, line_addr, err_unexp
  );
  modport master (
    output fetch_req, fetch_addr, rdat_m_valid, rdat_m_data, line_ready,
    input  fetch_ack, rstart_rq, rin_addr, line_valid, line_data, line_addr, err_unexp
  );
endinterface

// File: rtl/rd_line_fetch_ctrl.sv
// rd_line_fetch_ctrl: queues line fetches, issues credit-limited reads and returns lines in issue order
module rd_line_fetch_ctrl #(
  parameter int AFIFO_DEPTH = 4,
  parameter int MAX_OUT     = 2
) (
  input logic           clk,
  input logic           rst_n,
  rd_line_fetch_if.slave bus
);
  localparam int AW = $clog2(AFIFO_DEPTH);
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [AW:0] A_FULL  = (AW + 1)'(AFIFO_DEPTH);
  localparam logic [CW:0] CREDITS = (CW + 1)'(MAX_OUT);
  typedef enum logic {IDLE, ISSUE} state_t;
  state_t        state, state_nx;
  logic          rdy;
  logic [31:0]   afifo [AFIFO_DEPTH];
  logic [AW-1:0] a_wr, a_rd;
  logic [AW:0]   a_cnt;
  logic [31:0]   tags [2];
  logic          t_wr, t_rd;
  logic [CW-1:0] inflight, ret_count;
  logic [31:0]   rb_addr [2];
  logic [127:0]  rb_data [2];
  logic          b_wr, b_rd;
  logic          push, issue, ret, unexp, take, credit, err;
  // rdy holds fetch_ack low during reset and releases it on the first edge afterwards
  assign bus.fetch_ack  = rdy && (a_cnt != A_FULL);
  assign push           = bus.fetch_req && bus.fetch_ack;
  assign credit         = ({1'b0, inflight} + {1'b0, ret_count}) < CREDITS;
  assign ret            = bus.rdat_m_valid && (inflight != '0);
  assign unexp          = bus.rdat_m_valid && (inflight == '0);
  assign bus.line_valid = ret_count != '0;
  assign take           = bus.line_valid && bus.line_ready;
  assign bus.line_addr  = bus.line_valid ? rb_addr[b_rd] : '0;
  assign bus.line_data  = bus.line_valid ? rb_data[b_rd] : '0;
  assign bus.err_unexp  = err;
  // issue FSM: decide in IDLE on queue and credit, pulse one read start in ISSUE
  always_comb begin
    state_nx      = IDLE;
    issue         = 1'b0;
    bus.rin_addr  = '0;
    if (state == IDLE) state_nx = (a_cnt != '0 && credit) ? ISSUE : IDLE;
    else begin
      issue        = 1'b1;
      bus.rin_addr = afifo[a_rd];
    end
  end
  assign bus.rstart_rq = issue;
  // control state, pointers and counters; reset drops everything queued or in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rdy       <= 1'b0;
      a_wr      <= '0;
      a_rd      <= '0;
      a_cnt     <= '0;
      t_wr      <= 1'b0;
      t_rd      <= 1'b0;
      b_wr      <= 1'b0;
      b_rd      <= 1'b0;
      inflight  <= '0;
      ret_count <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_nx;
      rdy       <= 1'b1;
      if (push) a_wr <= a_wr + AW'(1);
      if (issue) a_rd <= a_rd + AW'(1);
      a_cnt     <= a_cnt + (AW + 1)'(push) - (AW + 1)'(issue);
      if (issue) t_wr <= ~t_wr;
      if (ret) t_rd <= ~t_rd;
      if (ret) b_wr <= ~b_wr;
      if (take) b_rd <= ~b_rd;
      inflight  <= inflight + CW'(issue) - CW'(ret);
      ret_count <= ret_count + CW'(ret) - CW'(take);
      if (unexp) err <= 1'b1;
    end
  end
  // storage arrays: address FIFO, issue-order tags and the return buffer need no reset
  always_ff @(posedge clk) begin
    if (push) afifo[a_wr] <= {bus.fetch_addr[31:4], 4'h0};
    if (issue) tags[t_wr] <= afifo[a_rd];
    if (ret) begin
      rb_addr[b_wr] <= tags[t_rd];
      rb_data[b_wr] <= bus.rdat_m_data;
    end
  end
endmodule
